// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port word memory between instruction fetch
// and data load/store; each grant runs IDLE -> ACCESS -> RESP with bad addresses rejected.
module mem_arbiter #(
  parameter logic [31:0] STARTING_ADDR   = 32'h01000000,
  parameter logic [31:0] MEM_DEPTH_BYTES = 32'h00100000,
  parameter int          CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_ack,
  output logic             if_err,
  output logic [31:0]      if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_ack,
  output logic             d_err,
  output logic [31:0]      d_rdata,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_data_in,
  output logic             mem_read_write,
  input  logic [31:0]      mem_data_out,
  output logic [CNT_W-1:0] if_grant_cnt,
  output logic [CNT_W-1:0] d_grant_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic       SEL_IF  = 1'b0;
  localparam logic       SEL_D   = 1'b1;
  localparam logic [32:0] LO_ADDR = {1'b0, STARTING_ADDR};
  localparam logic [32:0] HI_ADDR = {1'b0, STARTING_ADDR} + {1'b0, MEM_DEPTH_BYTES} - 33'd1;

  state_t      state_r;
  logic        last_sel_r;
  logic        sel_r;
  logic        we_r;
  logic        err_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        grant_sel_s;
  logic [31:0] grant_addr_s;

  // 33-bit compare so addresses near the top of the 32-bit space cannot wrap into range
  function automatic logic addr_bad(input logic [31:0] a);
    logic [32:0] a33;
    a33 = {1'b0, a};
    return (a[1:0] != 2'b00) || (a33 < LO_ADDR) || ((a33 + 33'd3) > HI_ADDR);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign mem_address = addr_r;
  assign mem_data_in = wdata_r;

  // grant selection: on a tie the requester not served last wins
  always_comb begin
    grant_sel_s = SEL_IF;
    if (if_req && d_req) begin
      grant_sel_s = ~last_sel_r;
    end else if (d_req) begin
      grant_sel_s = SEL_D;
    end else begin
      grant_sel_s = SEL_IF;
    end
    grant_addr_s = (grant_sel_s == SEL_D) ? d_addr : if_addr;
  end

  // write strobe gated by reset so a store caught by reset in ACCESS never commits
  always_comb begin
    mem_read_write = 1'b0;
    if ((state_r == ACCESS) && we_r && !err_r && !reset) begin
      mem_read_write = 1'b1;
    end else begin
      mem_read_write = 1'b0;
    end
  end

  // transaction FSM with registered responses and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      last_sel_r   <= SEL_D;
      sel_r        <= SEL_IF;
      we_r         <= 1'b0;
      err_r        <= 1'b0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      if_ack       <= 1'b0;
      if_err       <= 1'b0;
      if_rdata     <= 32'd0;
      d_ack        <= 1'b0;
      d_err        <= 1'b0;
      d_rdata      <= 32'd0;
      if_grant_cnt <= {CNT_W{1'b0}};
      d_grant_cnt  <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          if_err <= 1'b0;
          d_err  <= 1'b0;
          if (if_req || d_req) begin
            sel_r   <= grant_sel_s;
            addr_r  <= grant_addr_s;
            we_r    <= (grant_sel_s == SEL_D) ? d_we : 1'b0;
            wdata_r <= (grant_sel_s == SEL_D) ? d_wdata : wdata_r;
            err_r   <= addr_bad(grant_addr_s);
            state_r <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          last_sel_r <= sel_r;
          if (sel_r == SEL_D) begin
            d_rdata     <= (err_r || we_r) ? 32'd0 : mem_data_out;
            d_ack       <= 1'b1;
            d_err       <= err_r;
            d_grant_cnt <= sat_inc(d_grant_cnt);
          end else begin
            if_rdata     <= err_r ? 32'd0 : mem_data_out;
            if_ack       <= 1'b1;
            if_err       <= err_r;
            if_grant_cnt <= sat_inc(if_grant_cnt);
          end
          state_r <= RESP;
        end
        RESP: begin
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          if_err  <= 1'b0;
          d_err   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          if_err  <= 1'b0;
          d_err   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port byte-addressed main memory between two requesters: instruction fetch (read-only) and data load/store (read/write).
- Sits between the pipeline's fetch and memory stages and the main memory model.
- Runs one word access per grant with a req/ack handshake and round-robin fairness.
- Rejects out-of-range and misaligned addresses without touching memory.

Parameters:
- STARTING_ADDR, 'h01000000, byte address of main-memory word 0.
- MEM_DEPTH_BYTES, 'h0100000, size of the memory window in bytes.
- CNT_W, 16, width of the saturating grant counters.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  32  fetch byte address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse: fetch transaction complete.
- if_err  out  1  valid with if_ack: address rejected.
- if_rdata  out  32  fetch read data; valid with if_ack.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  in  32  data byte address; stable while d_req is high.
- d_wdata  in  32  store data; stable while d_req is high.
- d_ack  out  1  one-cycle pulse: data transaction complete.
- d_err  out  1  valid with d_ack: address rejected.
- d_rdata  out  32  load data; valid with d_ack; 0 for stores.
- mem_address  out  32  to memory address.
- mem_data_in  out  32  to memory write data.
- mem_read_write  out  1  to memory; 0 = READ, 1 = WRITE.
- mem_data_out  in  32  from memory; combinational read data.
- if_grant_cnt  out  CNT_W  saturating count of completed fetch transactions.
- d_grant_cnt  out  CNT_W  saturating count of completed data transactions.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sample if_req/d_req at posedge.
  - If either is high: latch sel (0 = fetch, 1 = data), addr, we (0 for fetch), wdata, and err_l; go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one request pending: grant it.
  - Both pending: grant the requester not served last, tracked by register last_sel.
  - Reset value of last_sel = data, so fetch wins the first tie.
  - last_sel updates on the ACCESS->RESP transition.
- Address check, registered as err_l:
  - err_l = 1 if addr[1:0] != 0, addr < STARTING_ADDR, or addr + 3 > STARTING_ADDR + MEM_DEPTH_BYTES - 1.
  - Compare in 33 bits so wrap-around addresses (e.g. 'hFFFFFFFC) are rejected.
- ACCESS (exactly one cycle):
  - mem_address = latched addr.
  - mem_data_in = latched wdata.
  - mem_read_write = 1 only if we=1, err_l=0 and reset=0; 0 otherwise.
  - At posedge: memory commits the write; arbiter registers mem_data_out into the selected rdata register (0 if err_l or store); go to RESP.
- RESP (exactly one cycle):
  - Selected ack = 1; selected err = err_l; increment the selected counter (saturates at all-ones).
  - Next state is always IDLE. This guarantees a held req is not re-granted during its own ack cycle.
- Outside ACCESS: mem_read_write = 0; mem_address and mem_data_in hold their last values.
- Latency: req seen at posedge N -> memory access in cycle N+1 -> ack high in cycle N+2.
  - Throughput: one transaction per 3 cycles.
  - A losing requester waits one extra transaction (max wait 6 cycles from req to start of ACCESS).
- Output stability:
  - rdata registers hold their value until the next ack for that port.
  - ack and err are low except in RESP.
- Reset (synchronous; also mid-transaction):
  - state = IDLE; last_sel = data; both acks, errs, rdatas, and counters = 0; mem_address = 0; mem_data_in = 0.
  - mem_read_write is forced 0 combinationally while reset is high, so a store in ACCESS when reset is asserted is NOT committed.
  - The aborted transaction is never acked; the requester must keep req high, and it is re-served after reset deasserts.
- A req dropped before its ack is a protocol violation; behaviour is undefined, and the bench asserts against it.

Test Plan:
- Fetch only: after reset, if_req=1, if_addr='h01000000 with memory word 0 = 'h00000513 -> if_ack in cycle 3 after req, if_rdata='h00000513, if_err=0, mem_read_write never 1, if_grant_cnt=1.
- Store then load:
  - d_we=1, d_addr='h01000010, d_wdata='hDEADBEEF -> mem_read_write=1 for exactly one cycle, d_ack 2 cycles after grant.
  - Then load of the same address -> d_rdata='hDEADBEEF.
- Contention: if_req and d_req both held for 4 transactions -> grant order fetch, data, fetch, data; acks every 3 cycles; never both acks in one cycle; final counters 2/2.
- Errors:
  - d_addr='h01000002 store -> d_err=1, d_rdata=0, no memory write.
  - if_addr='h00FFFFFC, 'h01100000, and 'hFFFFFFFC -> if_err=1 each.
  - if_addr='h010FFFFC -> if_err=0.
- Reset mid-store: assert reset in the ACCESS cycle of a store to 'h01000020 (old value 'h11111111) -> no ack, word still 'h11111111; after release with d_req held -> store completes normally.
- Counter saturation (CNT_W=2): 5 fetches -> if_grant_cnt reads 1, 2, 3, 3, 3.
